// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock controller: state encoding, parameter
// defaults and a small sizing helper.
package pll_ctrl_pkg;

    localparam int unsigned PLL_RST_CYCLES_DEF       = 16;
    localparam int unsigned LOCK_FILTER_CYCLES_DEF   = 64;
    localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF  = 50000;
    localparam int unsigned RELEASE_DELAY_CYCLES_DEF = 256;
    localparam int unsigned MAX_RETRIES_DEF          = 4;

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StRelease  = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, filters lock, times out and retries,
// and holds the core in reset until lock has been stable for a release delay.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES       = PLL_RST_CYCLES_DEF,
    parameter int unsigned LOCK_FILTER_CYCLES   = LOCK_FILTER_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = LOCK_TIMEOUT_CYCLES_DEF,
    parameter int unsigned RELEASE_DELAY_CYCLES = RELEASE_DELAY_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES          = MAX_RETRIES_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_lock_i,
    input  logic       req_rst_i,
    output logic       pll_rst_o,
    output logic       core_rst_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] lock_loss_cnt_o
);

    localparam int unsigned CntMax = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                          RELEASE_DELAY_CYCLES);
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned FiltW  = $clog2(LOCK_FILTER_CYCLES + 1);

    localparam logic [CntW-1:0]  RstLast     = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0]  TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0]  ReleaseLast = CntW'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [FiltW-1:0] FiltFull    = FiltW'(LOCK_FILTER_CYCLES);
    localparam logic [3:0]       RetryMax    = 4'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [FiltW-1:0] filt_q, filt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_rst_q, core_rst_q, locked_q, fail_q;
    logic             lock_sync;
    logic             lock_good;

    sync_2ff u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lock_i),
        .q_o   (lock_sync)
    );

    assign lock_good = (filt_q == FiltFull);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        retry_d = retry_q;
        loss_d  = loss_q;
        filt_d  = filt_q;

        unique case (state_q)
            StPllRst: begin
                if (cnt_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                // A good lock in the timeout cycle still counts as success.
                if (lock_good) begin
                    state_d = StRelease;
                end else if (cnt_q == TimeoutLast) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_d == RetryMax) ? StFail : StPllRst;
                end
            end
            StRelease: begin
                if (!lock_sync) begin
                    state_d = StWaitLock;
                end else if (cnt_q == ReleaseLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!lock_sync) begin
                    state_d = StPllRst;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StPllRst;
            end
        endcase

        if (req_rst_i) begin
            state_d = StPllRst;
            retry_d = '0;
            loss_d  = loss_q;
        end

        if (!lock_sync) begin
            filt_d = '0;
        end else if (!lock_good) begin
            filt_d = filt_q + FiltW'(1);
        end

        // Every state entry (including a forced restart) starts a fresh count.
        if (req_rst_i || (state_d != state_q)) begin
            cnt_d = '0;
            if (state_d == StPllRst) filt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StPllRst;
            cnt_q      <= '0;
            filt_q     <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            pll_rst_q  <= (state_d == StPllRst);
            core_rst_q <= (state_d != StRun);
            locked_q   <= (state_d == StRun);
            fail_q     <= (state_d == StFail);
        end
    end

    assign pll_rst_o       = pll_rst_q;
    assign core_rst_o      = core_rst_q;
    assign locked_o        = locked_q;
    assign fail_o          = fail_q;
    assign retry_cnt_o     = retry_q;
    assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scenario bench for pll_lock_ctrl: expected timings come from the sequencing rules
// (sync depth, filter length, delays) applied to randomized lock waveforms.
module tb_pll_lock_ctrl;

    localparam int unsigned PLL_RST     = 4;
    localparam int unsigned FILTER      = 8;
    localparam int unsigned TIMEOUT     = 100;
    localparam int unsigned RELEASE     = 16;
    localparam int unsigned MAX_RETRIES = 3;
    // Drive-to-core_rst-release latency: one edge to the first sample, then 2+FILTER+RELEASE.
    localparam int ACQ_LAT = 1 + 2 + FILTER + RELEASE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       req_rst = 1'b0;
    logic       pll_rst, core_rst, locked, fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int loss_exp = 0;
    int retry_exp = 0;

    pll_lock_ctrl #(
        .PLL_RST_CYCLES       (PLL_RST),
        .LOCK_FILTER_CYCLES   (FILTER),
        .LOCK_TIMEOUT_CYCLES  (TIMEOUT),
        .RELEASE_DELAY_CYCLES (RELEASE),
        .MAX_RETRIES          (MAX_RETRIES)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pll_lock_i      (pll_lock),
        .req_rst_i       (req_rst),
        .pll_rst_o       (pll_rst),
        .core_rst_o      (core_rst),
        .locked_o        (locked),
        .fail_o          (fail),
        .retry_cnt_o     (retry_cnt),
        .lock_loss_cnt_o (lock_loss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the edge index at which the selected output first equals val, or -1.
    task automatic wait_sig(input int sel, input logic val, input int budget, output int at);
        logic s;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            case (sel)
                0:       s = pll_rst;
                1:       s = core_rst;
                2:       s = locked;
                default: s = fail;
            endcase
            if (s === val) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int r, at;
        rst = 1'b1;
        pll_lock = 1'b0;
        req_rst = 1'b0;
        repeat (3) tick();
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL rst_pll_rst: got %b want 1", pll_rst); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %b want 1", core_rst); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b want 0", locked); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL rst_fail: got %b want 0", fail); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL rst_retry: got %0d want 0", retry_cnt); end
        checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL rst_loss: got %0d want 0", lock_loss_cnt); end
        rst = 1'b0;
        r = cyc;
        wait_sig(0, 1'b0, 20, at);
        checks++;
        if (at - r != PLL_RST) begin
            errors++; $display("FAIL rst_pulse_len: got %0d want %0d", at - r, PLL_RST);
        end
    endtask

    // Entered just after pll_rst has fallen.
    task automatic test_lock_acquire();
        int p, at;
        repeat ($urandom_range(5, 40)) tick();
        pll_lock = 1'b1;
        p = cyc;
        wait_sig(1, 1'b0, 200, at);
        checks++;
        if (at - p != ACQ_LAT) begin
            errors++; $display("FAIL acquire_latency: got %0d want %0d", at - p, ACQ_LAT);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL acquire_locked: got %b want 1", locked); end
        checks++; if (retry_cnt !== 4'(retry_exp)) begin errors++; $display("FAIL acquire_retry: got %0d want %0d", retry_cnt, retry_exp); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL acquire_fail: got %b want 0", fail); end
    endtask

    task automatic test_lock_loss();
        int p, len, at, t_core, t_rise, t_fall;
        for (int n = 0; n < 2; n++) begin
            len = $urandom_range(2, 4);
            pll_lock = 1'b0;
            p = cyc;
            t_core = -1; t_rise = -1; t_fall = -1;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (i == len) pll_lock = 1'b1;
                if (core_rst === 1'b1 && t_core < 0) t_core = cyc;
                if (pll_rst === 1'b1 && t_rise < 0) t_rise = cyc;
                if (t_rise >= 0 && pll_rst === 1'b0 && t_fall < 0) t_fall = cyc;
            end
            loss_exp = (loss_exp < 255) ? loss_exp + 1 : 255;
            checks++;
            if (t_core < 0 || t_core - p > 3) begin
                errors++; $display("FAIL loss_core_rst_delay: got %0d want <=3", t_core - p);
            end
            checks++;
            if (lock_loss_cnt !== 8'(loss_exp)) begin
                errors++; $display("FAIL loss_count: got %0d want %0d", lock_loss_cnt, loss_exp);
            end
            checks++;
            if (t_rise < 0 || t_fall - t_rise != PLL_RST) begin
                errors++; $display("FAIL loss_pll_pulse: got %0d want %0d", t_fall - t_rise, PLL_RST);
            end
            wait_sig(2, 1'b1, 300, at);
            checks++;
            if (at < 0 || core_rst !== 1'b0) begin
                errors++; $display("FAIL loss_relock: locked_at %0d core_rst %b want RUN", at, core_rst);
            end
        end
    endtask

    task automatic test_glitch();
        int f, g, at, p;
        // Lock removed together with req_rst: the restart wins, so no lock-loss event.
        pll_lock = 1'b0;
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        retry_exp = 0;
        wait_sig(0, 1'b0, 20, f);
        repeat ($urandom_range(2, 10)) tick();
        g = $urandom_range(1, FILTER - 1);
        pll_lock = 1'b1;
        repeat (g) tick();
        pll_lock = 1'b0;
        wait_sig(0, 1'b1, 200, at);
        retry_exp = 1;
        checks++;
        if (at - f != TIMEOUT) begin
            errors++; $display("FAIL glitch_timeout: glitch %0d, got %0d want %0d", g, at - f, TIMEOUT);
        end
        checks++; if (retry_cnt !== 4'(retry_exp)) begin errors++; $display("FAIL glitch_retry: got %0d want %0d", retry_cnt, retry_exp); end
        checks++; if (lock_loss_cnt !== 8'(loss_exp)) begin errors++; $display("FAIL glitch_loss: got %0d want %0d", lock_loss_cnt, loss_exp); end
        wait_sig(0, 1'b0, 20, f);
        checks++;
        if (f - at != PLL_RST) begin
            errors++; $display("FAIL glitch_retry_pulse: got %0d want %0d", f - at, PLL_RST);
        end
        repeat ($urandom_range(2, 10)) tick();
        pll_lock = 1'b1;
        repeat ($urandom_range(1, FILTER - 1)) tick();
        pll_lock = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        pll_lock = 1'b1;
        p = cyc;
        wait_sig(1, 1'b0, 200, at);
        checks++;
        if (at - p != ACQ_LAT) begin
            errors++; $display("FAIL glitch_filter_restart: got %0d want %0d", at - p, ACQ_LAT);
        end
        checks++; if (retry_cnt !== 4'(retry_exp)) begin errors++; $display("FAIL glitch_run_retry: got %0d want %0d", retry_cnt, retry_exp); end
    endtask

    task automatic test_timeout_fail();
        int t0, n_rise, n_fall, t_fail;
        int rise[8];
        int fall[8];
        logic prev;
        pll_lock = 1'b0;
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        retry_exp = 0;
        t0 = cyc;
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL tmo_start_pll_rst: got %b want 1", pll_rst); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL tmo_start_retry: got %0d want 0", retry_cnt); end
        rise[0] = t0; n_rise = 1; n_fall = 0; t_fail = -1; prev = 1'b1;
        for (int i = 0; i < 450; i++) begin
            tick();
            if (pll_rst !== prev) begin
                if (pll_rst === 1'b1 && n_rise < 8) begin rise[n_rise] = cyc; n_rise++; end
                else if (pll_rst === 1'b0 && n_fall < 8) begin fall[n_fall] = cyc; n_fall++; end
                prev = pll_rst;
            end
            if (fail === 1'b1 && t_fail < 0) t_fail = cyc;
        end
        retry_exp = MAX_RETRIES;
        checks++;
        if (n_rise != MAX_RETRIES || n_fall != MAX_RETRIES) begin
            errors++; $display("FAIL tmo_pulse_count: got %0d/%0d want %0d", n_rise, n_fall, MAX_RETRIES);
        end
        for (int k = 0; k < n_fall && k < n_rise; k++) begin
            checks++;
            if (fall[k] - rise[k] != PLL_RST) begin
                errors++; $display("FAIL tmo_pulse_len[%0d]: got %0d want %0d", k, fall[k] - rise[k], PLL_RST);
            end
            if (k + 1 < n_rise) begin
                checks++;
                if (rise[k+1] - fall[k] != TIMEOUT) begin
                    errors++; $display("FAIL tmo_gap[%0d]: got %0d want %0d", k, rise[k+1] - fall[k], TIMEOUT);
                end
            end
        end
        checks++;
        if (n_fall == 0 || t_fail < 0 || t_fail - fall[n_fall-1] != TIMEOUT) begin
            errors++; $display("FAIL tmo_fail_time: fail_at %0d want last fall + %0d", t_fail, TIMEOUT);
        end
        checks++; if (retry_cnt !== 4'(retry_exp)) begin errors++; $display("FAIL tmo_retry: got %0d want %0d", retry_cnt, retry_exp); end
        checks++; if (fail !== 1'b1) begin errors++; $display("FAIL tmo_fail: got %b want 1", fail); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL tmo_core_rst: got %b want 1", core_rst); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL tmo_locked: got %b want 0", locked); end
        checks++; if (lock_loss_cnt !== 8'(loss_exp)) begin errors++; $display("FAIL tmo_loss: got %0d want %0d", lock_loss_cnt, loss_exp); end
    endtask

    task automatic test_req_rst();
        int f, at;
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        retry_exp = 0;
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL req_fail_pll_rst: got %b want 1", pll_rst); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL req_fail_fail: got %b want 0", fail); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL req_fail_retry: got %0d want 0", retry_cnt); end
        checks++; if (lock_loss_cnt !== 8'(loss_exp)) begin errors++; $display("FAIL req_fail_loss: got %0d want %0d", lock_loss_cnt, loss_exp); end
        wait_sig(0, 1'b0, 20, f);
        repeat (TIMEOUT - 1) tick();
        // This pulse is sampled on the same edge as the WAIT_LOCK timeout.
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL req_tmo_pll_rst: got %b want 1", pll_rst); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL req_tmo_retry: got %0d want 0", retry_cnt); end
        checks++; if (lock_loss_cnt !== 8'(loss_exp)) begin errors++; $display("FAIL req_tmo_loss: got %0d want %0d", lock_loss_cnt, loss_exp); end
        wait_sig(0, 1'b0, 20, at);
        checks++;
        if (at - (f + TIMEOUT) != PLL_RST) begin
            errors++; $display("FAIL req_tmo_pulse: got %0d want %0d", at - (f + TIMEOUT), PLL_RST);
        end
    endtask

    // Entered just after pll_rst has fallen.
    task automatic test_rst_async();
        int at, r;
        pll_lock = 1'b1;
        repeat (1 + 2 + FILTER + $urandom_range(1, RELEASE - 2)) tick();
        checks++;
        if (pll_rst !== 1'b0 || core_rst !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL async_pre_release: pll_rst %b core_rst %b locked %b want 0 1 0", pll_rst, core_rst, locked);
        end
        #3 rst = 1'b1;
        #1;
        loss_exp = 0;
        retry_exp = 0;
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL async_pll_rst: got %b want 1", pll_rst); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL async_core_rst: got %b want 1", core_rst); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL async_locked: got %b want 0", locked); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL async_fail: got %b want 0", fail); end
        checks++; if (retry_cnt !== 4'(retry_exp)) begin errors++; $display("FAIL async_retry: got %0d want %0d", retry_cnt, retry_exp); end
        checks++; if (lock_loss_cnt !== 8'(loss_exp)) begin errors++; $display("FAIL async_loss: got %0d want %0d", lock_loss_cnt, loss_exp); end
        tick();
        rst = 1'b0;
        r = cyc;
        wait_sig(0, 1'b0, 20, at);
        checks++;
        if (at - r != PLL_RST) begin
            errors++; $display("FAIL async_restart_pulse: got %0d want %0d", at - r, PLL_RST);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_lock_loss();
        test_glitch();
        test_timeout_fail();
        test_req_rst();
        test_rst_async();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: number of clk cycles pll_rst is held high per PLL reset attempt.
REQ-002 Parameter LOCK_FILTER_CYCLES, default 64: consecutive synchronized-high lock samples required before lock counts as good.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 50000: clk cycles allowed in WAIT_LOCK per attempt (1 ms at 50 MHz).
REQ-004 Parameter RELEASE_DELAY_CYCLES, default 256: clk cycles between good lock and core_rst deassertion.
REQ-005 Parameter MAX_RETRIES, default 4, range 1..15: failed attempts tolerated before FAIL.
REQ-006 clk  in  1  free-running PLL reference clock (50 MHz board oscillator), never a PLL output.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 pll_lock  in  1  PLL lock indication, asynchronous to clk.
REQ-009 req_rst  in  1  single-cycle clk-domain pulse requesting a fresh PLL reset sequence.
REQ-010 pll_rst  out  1  reset to the PLL RST pin, active-high.
REQ-011 core_rst  out  1  core reset, active-high, clk domain; consumers in the PLL clock domain resynchronize it.
REQ-012 locked  out  1  high only in RUN.
REQ-013 fail  out  1  high only in FAIL.
REQ-014 retry_cnt  out  4  timeouts since last rst/req_rst.
REQ-015 lock_loss_cnt  out  8  lock-loss events in RUN, saturating at 255.

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchronizer before any use; lock_sync is its output.
REQ-017 Filter counter SHALL increment while lock_sync=1, clear to 0 on lock_sync=0, saturate at LOCK_FILTER_CYCLES; lock_good=1 when counter equals LOCK_FILTER_CYCLES; the counter SHALL clear on entry to PLL_RST.
REQ-018 States: PLL_RST, WAIT_LOCK, RELEASE, RUN, FAIL; one shared cycle counter cleared on every state entry.
REQ-019 PLL_RST: pll_rst=1 and core_rst=1; after exactly PLL_RST_CYCLES cycles the FSM SHALL go to WAIT_LOCK.
REQ-020 WAIT_LOCK: pll_rst=0 and core_rst=1; lock_good goes to RELEASE.
REQ-021 WAIT_LOCK timeout: when the counter reaches LOCK_TIMEOUT_CYCLES-1 without lock_good, retry_cnt SHALL increment; the next state is FAIL if the new value equals MAX_RETRIES, otherwise PLL_RST.
REQ-022 lock_good and timeout in the same cycle: lock_good wins.
REQ-023 RELEASE: core_rst=1; lock_sync=0 goes to WAIT_LOCK (counter cleared, no retry increment); after RELEASE_DELAY_CYCLES cycles with lock held, go to RUN.
REQ-024 RUN: core_rst=0, locked=1; lock_sync=0 SHALL set core_rst=1 on the next cycle, increment lock_loss_cnt (saturating), and go to PLL_RST.
REQ-025 FAIL: pll_rst=0, core_rst=1, fail=1; the FSM SHALL stay in FAIL until rst or req_rst.
REQ-026 req_rst SHALL, from any state, force PLL_RST and clear retry_cnt, leaving lock_loss_cnt unchanged; it has priority over every other transition in the same cycle.
REQ-027 All outputs SHALL be registered; core_rst SHALL never be low outside RUN.

Reset
REQ-028 While rst=1: state=PLL_RST, counters=0, synchronizer=0, pll_rst=1, core_rst=1, locked=0, fail=0, retry_cnt=0, lock_loss_cnt=0.
REQ-029 The first clk edge after rst falls SHALL count as PLL_RST cycle 1; rst asserted mid-sequence SHALL restart from REQ-028 immediately (asynchronously).

Structure
REQ-030 State encodings and parameter default values SHALL live in shared package pll_ctrl_pkg.
REQ-031 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, reusable for other asynchronous inputs.

Verification (bench overrides: PLL_RST=4, FILTER=8, TIMEOUT=100, RELEASE=16, MAX_RETRIES=3)
REQ-032 Lock rises 20 cycles after pll_rst falls and stays high -> core_rst falls exactly 2+8+16 cycles after the first lock sample at the synchronizer (±1); locked=1; retry_cnt=0.
REQ-033 pll_lock held at 0 -> 3 pll_rst pulses of 4 cycles, 100 cycles apart; retry_cnt=3; fail=1; core_rst stays 1.
REQ-034 In RUN, pll_lock dropped for 3 cycles -> core_rst=1 within 3 clk cycles; lock_loss_cnt=1; new 4-cycle pll_rst pulse; RUN regained after relock.
REQ-035 Lock glitch of 5 high cycles in WAIT_LOCK -> no transition to RELEASE; the filter restarts from 0.
REQ-036 req_rst in FAIL, coincident with a timeout in WAIT_LOCK -> PLL_RST entered, retry_cnt=0, lock_loss_cnt unchanged.
REQ-037 rst asserted mid-RELEASE -> all outputs at REQ-028 values with no clk edge required.
